// File: rtl/switch_sum_display.sv
// rtl/switch_sum_display.sv - synchronised switch adder with LED sum and muxed hex display
// Optional blanking dead time at the start of each digit slot: define DIGIT_BLANK_EN.
module switch_sum_display #(
    parameter int WIDTH        = 4,
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   switch1,
    input  logic [WIDTH-1:0]   switch2,
    output logic [WIDTH:0]     leds,
    output logic [6:0]         seg,
    output logic [WIDTH/2-1:0] anode,
    output logic               frame_start
);
    localparam int NUM_DIGITS = 2 * WIDTH / 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("WIDTH must be a multiple of 4 and at least 4");
        end
        if (REFRESH_DIV < 2) begin : g_bad_div
            $error("REFRESH_DIV must be at least 2");
        end
        if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
            $error("BLANK_CYCLES must be less than REFRESH_DIV");
        end
    endgenerate

    logic [WIDTH-1:0]      r_a_meta;
    logic [WIDTH-1:0]      r_a_sync;
    logic [WIDTH-1:0]      r_b_meta;
    logic [WIDTH-1:0]      r_b_sync;
    logic [WIDTH:0]        r_leds;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_frame;

    logic [2*WIDTH-1:0]    w_digits;
    logic [3:0]            w_nibble;
    logic [6:0]            w_hex;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_anode;
    logic                  w_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_meta <= '0;
            r_a_sync <= '0;
            r_b_meta <= '0;
            r_b_sync <= '0;
            r_leds   <= '0;
        end else begin
            r_a_meta <= switch1;
            r_a_sync <= r_a_meta;
            r_b_meta <= switch2;
            r_b_sync <= r_b_meta;
            r_leds   <= {1'b0, r_a_sync} + {1'b0, r_b_sync};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand B nibbles sit above operand A, so the digit index selects directly.
    assign w_digits = {r_b_sync, r_a_sync};
    assign w_nibble = w_digits[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_hex = 7'h7F;
        case (w_nibble)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    always_comb begin
        w_anode        = '1;
        w_anode[r_idx] = 1'b0;
        w_seg          = w_hex;
        w_frame        = (r_cnt == '0) && (r_idx == '0);
`ifdef DIGIT_BLANK_EN
        if (r_cnt < CNT_W'(BLANK_CYCLES)) begin
            w_anode = '1;
            w_seg   = 7'h7F;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg   <= 7'h7F;
            r_anode <= '1;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg;
            r_anode <= w_anode;
            r_frame <= w_frame;
        end
    end

    assign leds        = r_leds;
    assign seg         = r_seg;
    assign anode       = r_anode;
    assign frame_start = r_frame;
endmodule

// File: tb/tb_switch_sum_display.sv
// tb/tb_switch_sum_display.sv - randomized self-checking bench for switch_sum_display
module tb_switch_sum_display;
    localparam int RD = 4;
    localparam int BC = 1;
`ifdef DIGIT_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam int HMAX = 2048;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sa4 = '0, sb4 = '0;
    logic [7:0] sa8 = '0, sb8 = '0;
    logic [4:0] leds4;
    logic [8:0] leds8;
    logic [6:0] seg4, seg8;
    logic [1:0] anode4;
    logic [3:0] anode8;
    logic       fs4, fs8;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] ha4 [0:HMAX-1];
    logic [7:0] hb4 [0:HMAX-1];
    logic [7:0] ha8 [0:HMAX-1];
    logic [7:0] hb8 [0:HMAX-1];
    logic [6:0] hex_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    switch_sum_display #(.WIDTH(4), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut4 (
        .clk(clk), .reset(reset), .switch1(sa4), .switch2(sb4),
        .leds(leds4), .seg(seg4), .anode(anode4), .frame_start(fs4));

    switch_sum_display #(.WIDTH(8), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut8 (
        .clk(clk), .reset(reset), .switch1(sa8), .switch2(sb8),
        .leds(leds8), .seg(seg8), .anode(anode8), .frame_start(fs8));

    always #5 clk = ~clk;

    // Record what the switches held at each edge since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0;
        end else begin
            if (cyc < HMAX) begin
                ha4[cyc] = {4'h0, sa4};
                hb4[cyc] = {4'h0, sb4};
                ha8[cyc] = sa8;
                hb8[cyc] = sb8;
            end
            cyc = cyc + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] op_at(int which, int e);
        if (e < 0 || e >= HMAX) return 8'h00;
        case (which)
            0: return ha4[e];
            1: return hb4[e];
            2: return ha8[e];
            default: return hb8[e];
        endcase
    endfunction

    function automatic logic [6:0] m_seg(int nd, logic [7:0] a, logic [7:0] b, int n);
        int k;
        logic [7:0] v;
        logic [3:0] nib;
        k = (n / RD) % nd;
        if (BLANK && (n % RD) < BC) return 7'h7F;
        v = (k < nd / 2) ? a : b;
        nib = 4'(v >> (4 * (k % (nd / 2))));
        return hex_tbl[nib];
    endfunction

    function automatic logic [3:0] m_anode(int nd, int n);
        logic [3:0] r;
        r = 4'hF;
        if (!(BLANK && (n % RD) < BC)) r[(n / RD) % nd] = 1'b0;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        sa4 = '0; sb4 = '0; sa8 = '0; sb8 = '0;
        repeat (3) step();
        checks += 8;
        if (leds4 !== 5'h00) begin errors++; $display("FAIL reset_leds4 got=%h want=00", leds4); end
        if (seg4 !== 7'h7F) begin errors++; $display("FAIL reset_seg4 got=%h want=7f", seg4); end
        if (anode4 !== 2'b11) begin errors++; $display("FAIL reset_anode4 got=%b want=11", anode4); end
        if (fs4 !== 1'b0) begin errors++; $display("FAIL reset_fs4 got=%b want=0", fs4); end
        if (leds8 !== 9'h000) begin errors++; $display("FAIL reset_leds8 got=%h want=000", leds8); end
        if (seg8 !== 7'h7F) begin errors++; $display("FAIL reset_seg8 got=%h want=7f", seg8); end
        if (anode8 !== 4'hF) begin errors++; $display("FAIL reset_anode8 got=%b want=1111", anode8); end
        if (fs8 !== 1'b0) begin errors++; $display("FAIL reset_fs8 got=%b want=0", fs8); end
    endtask

    task automatic test_latency();
        logic [1:0] ea;
        logic [6:0] es;
        sa4 = 4'hF; sb4 = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        step();
        ea = BLANK ? 2'b11 : 2'b10;
        es = BLANK ? 7'h7F : 7'h40;
        checks += 4;
        if (leds4 !== 5'h00) begin errors++; $display("FAIL lat_e1 got=%h want=00", leds4); end
        if (fs4 !== 1'b1) begin errors++; $display("FAIL first_fs got=%b want=1", fs4); end
        if (anode4 !== ea) begin errors++; $display("FAIL first_anode got=%b want=%b", anode4, ea); end
        if (seg4 !== es) begin errors++; $display("FAIL first_seg got=%h want=%h", seg4, es); end
        step();
        checks++;
        if (leds4 !== 5'h00) begin errors++; $display("FAIL lat_e2 got=%h want=00", leds4); end
        step();
        checks++;
        if (leds4 !== 5'h1E) begin errors++; $display("FAIL lat_e3 got=%h want=1e", leds4); end
    endtask

    task automatic test_digits();
        int guard;
        logic [1:0] ea;
        logic [6:0] es;
        sa4 = 4'h3; sb4 = 4'hA;
        repeat (3) step();
        guard = 0;
        while (((cyc - 1) % (2 * RD)) != (2 * RD - 1) && guard < 40) begin step(); guard++; end
        checks++;
        if (guard >= 40) begin errors++; $display("FAIL digits_align got=timeout want=frame_end"); end
        for (int i = 0; i < 2 * RD; i++) begin
            step();
            ea = (i < RD) ? 2'b10 : 2'b01;
            es = (i < RD) ? 7'b0110000 : 7'b0001000;
            if (BLANK && (i % RD) < BC) begin ea = 2'b11; es = 7'h7F; end
            checks += 2;
            if (anode4 !== ea) begin errors++; $display("FAIL digits_anode i=%0d got=%b want=%b", i, anode4, ea); end
            if (seg4 !== es) begin errors++; $display("FAIL digits_seg i=%0d got=%b want=%b", i, seg4, es); end
        end
    endtask

    task automatic test_refresh();
        int low0, low1, pulses, bad_fs, multi;
        low0 = 0; low1 = 0; pulses = 0; bad_fs = 0; multi = 0;
        for (int i = 0; i < 4 * RD; i++) begin
            step();
            if (anode4 == 2'b10) low0++;
            if (anode4 == 2'b01) low1++;
            if (anode4 == 2'b00) multi++;
            if (fs4) begin
                pulses++;
                if (((cyc - 1) % (2 * RD)) != 0) bad_fs++;
            end
        end
        checks += 5;
        if (low0 != 2 * (RD - (BLANK ? BC : 0))) begin errors++; $display("FAIL refresh_low0 got=%0d want=%0d", low0, 2 * (RD - (BLANK ? BC : 0))); end
        if (low1 != 2 * (RD - (BLANK ? BC : 0))) begin errors++; $display("FAIL refresh_low1 got=%0d want=%0d", low1, 2 * (RD - (BLANK ? BC : 0))); end
        if (pulses != 2) begin errors++; $display("FAIL refresh_pulses got=%0d want=2", pulses); end
        if (bad_fs != 0) begin errors++; $display("FAIL refresh_fs_phase got=%0d want=0", bad_fs); end
        if (multi != 0) begin errors++; $display("FAIL refresh_onehot got=%0d want=0", multi); end
    endtask

    task automatic test_width8();
        int guard;
        logic [3:0] ea;
        logic [6:0] es;
        logic [3:0] an_tbl [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] sg_tbl [0:3] = '{7'b0010010, 7'b0001000, 7'b0000011, 7'b0010010};
        sa8 = 8'hA5; sb8 = 8'h5B;
        repeat (3) step();
        checks++;
        if (leds8 !== 9'h100) begin errors++; $display("FAIL w8_leds got=%h want=100", leds8); end
        guard = 0;
        while (((cyc - 1) % (4 * RD)) != (4 * RD - 1) && guard < 40) begin step(); guard++; end
        checks++;
        if (guard >= 40) begin errors++; $display("FAIL w8_align got=timeout want=frame_end"); end
        for (int i = 0; i < 4 * RD; i++) begin
            step();
            ea = an_tbl[i / RD];
            es = sg_tbl[i / RD];
            if (BLANK && (i % RD) < BC) begin ea = 4'hF; es = 7'h7F; end
            checks += 3;
            if (anode8 !== ea) begin errors++; $display("FAIL w8_anode i=%0d got=%b want=%b", i, anode8, ea); end
            if (seg8 !== es) begin errors++; $display("FAIL w8_seg i=%0d got=%b want=%b", i, seg8, es); end
            if (fs8 !== (i == 0)) begin errors++; $display("FAIL w8_fs i=%0d got=%b want=%b", i, fs8, (i == 0)); end
        end
    endtask

    task automatic test_random();
        int n;
        logic [7:0] a4, b4, a8, b8;
        logic [3:0] ea;
        for (int i = 0; i < 300; i++) begin
            step();
            n = cyc - 1;
            a4 = op_at(0, n - 2); b4 = op_at(1, n - 2);
            a8 = op_at(2, n - 2); b8 = op_at(3, n - 2);
            checks += 8;
            if (leds4 !== 5'(a4 + b4)) begin errors++; $display("FAIL rnd_leds4 n=%0d got=%h want=%h", n, leds4, 5'(a4 + b4)); end
            if (leds8 !== 9'({1'b0, a8} + {1'b0, b8})) begin errors++; $display("FAIL rnd_leds8 n=%0d got=%h want=%h", n, leds8, 9'({1'b0, a8} + {1'b0, b8})); end
            if (seg4 !== m_seg(2, a4, b4, n)) begin errors++; $display("FAIL rnd_seg4 n=%0d got=%h want=%h", n, seg4, m_seg(2, a4, b4, n)); end
            if (seg8 !== m_seg(4, a8, b8, n)) begin errors++; $display("FAIL rnd_seg8 n=%0d got=%h want=%h", n, seg8, m_seg(4, a8, b8, n)); end
            ea = m_anode(2, n);
            if (anode4 !== ea[1:0]) begin errors++; $display("FAIL rnd_anode4 n=%0d got=%b want=%b", n, anode4, ea[1:0]); end
            if (anode8 !== m_anode(4, n)) begin errors++; $display("FAIL rnd_anode8 n=%0d got=%b want=%b", n, anode8, m_anode(4, n)); end
            if (fs4 !== ((n % (2 * RD)) == 0)) begin errors++; $display("FAIL rnd_fs4 n=%0d got=%b", n, fs4); end
            if (fs8 !== ((n % (4 * RD)) == 0)) begin errors++; $display("FAIL rnd_fs8 n=%0d got=%b", n, fs8); end
            if ($urandom_range(0, 2) == 0) begin
                sa4 = 4'($urandom); sb4 = 4'($urandom);
                sa8 = 8'($urandom); sb8 = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [1:0] ea;
        guard = 0;
        while (((cyc - 1) % (2 * RD)) != (RD + 1) && guard < 40) begin step(); guard++; end
        step();
        checks += 2;
        if (guard >= 40) begin errors++; $display("FAIL mid_align got=timeout want=slot1"); end
        if (anode4 !== 2'b01) begin errors++; $display("FAIL mid_pre_anode got=%b want=01", anode4); end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (anode4 !== 2'b11) begin errors++; $display("FAIL mid_anode got=%b want=11", anode4); end
        if (seg4 !== 7'h7F) begin errors++; $display("FAIL mid_seg got=%h want=7f", seg4); end
        if (leds4 !== 5'h00) begin errors++; $display("FAIL mid_leds got=%h want=00", leds4); end
        if (anode8 !== 4'hF) begin errors++; $display("FAIL mid_anode8 got=%b want=1111", anode8); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i <= RD; i++) begin
            step();
            ea = (i < RD) ? 2'b10 : 2'b01;
            if (BLANK && (i % RD) < BC) ea = 2'b11;
            checks++;
            if (anode4 !== ea) begin errors++; $display("FAIL mid_restart i=%0d got=%b want=%b", i, anode4, ea); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_digits();
        test_refresh();
        test_width8();
        test_random();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
